bus_responder: RTL

Host-side counterpart of the chip's serialized BF bus. It watches the chip's 12-bit output word, which carries the halted flag, the I/O phase code and the 8-bit bus byte. From that word it reassembles each bus operation (opcode, address high byte, address low byte), services it against a synchronous 32K×8 memory or the console byte streams, and drives the chip's 12-bit input word with the read data, `op_done` and the chip enable. It sits on the FPGA/test harness side, clocked by the same clock as the chip.

---
 rtl/bus_responder.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/bus_responder.sv
// Host-side responder for the chip's serialized bus: reassembles opcode/address/data phases and services memory or console.
// Latency: mem write strobe T+1, op_done T+2 (read T+3); console stalls on in_valid/out_ready; advances only while enabled.
module bus_responder (
    input  logic        clock,
    input  logic        reset,
    input  logic [11:0] chip_out,
    output logic [11:0] chip_in,
    input  logic        run,
    output logic [14:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    input  logic [7:0]  mem_rdata,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        chip_halted,
    output logic        proto_err
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_GOT_OP  = 3'd1;
    localparam logic [2:0] S_GOT_HI  = 3'd2;
    localparam logic [2:0] S_GOT_LO  = 3'd3;
    localparam logic [2:0] S_SERVE   = 3'd4;
    localparam logic [2:0] S_MEMWAIT = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;
    localparam logic [2:0] S_ERR     = 3'd7;

    localparam logic [2:0] PH_NONE = 3'd0;
    localparam logic [2:0] PH_OP   = 3'd1;
    localparam logic [2:0] PH_HI   = 3'd2;
    localparam logic [2:0] PH_LO   = 3'd3;
    localparam logic [2:0] PH_RW   = 3'd4;

    localparam logic [2:0] OP_MRD  = 3'd1;
    localparam logic [2:0] OP_MWR  = 3'd2;
    localparam logic [2:0] OP_CIN  = 3'd3;
    localparam logic [2:0] OP_COUT = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [2:0]  opcode_q, opcode_d;
    logic [14:0] addr_q, addr_d;
    logic [7:0]  data_q, data_d;
    logic [7:0]  bus_in_q, bus_in_d;
    logic        halted_q, halted_d;

    logic        enable;
    logic        op_done;
    logic [2:0]  phase;
    logic [7:0]  bus_byte;

    // Strobes and handshakes are gated by enable so they fire only on edges where the FSM advances.
    always_comb begin
        phase       = chip_out[10:8];
        bus_byte    = chip_out[7:0];
        proto_err   = (state_q == S_ERR);
        enable      = run & ~proto_err;
        op_done     = (state_q == S_DONE);
        mem_we      = enable && (state_q == S_SERVE) && (opcode_q == OP_MWR);
        mem_re      = enable && (state_q == S_SERVE) && (opcode_q == OP_MRD);
        in_ready    = enable && (state_q == S_SERVE) && (opcode_q == OP_CIN);
        out_valid   = enable && (state_q == S_SERVE) && (opcode_q == OP_COUT);
        mem_addr    = addr_q;
        mem_wdata   = data_q;
        out_data    = data_q;
        chip_halted = halted_q;
        chip_in     = {2'b00, enable, op_done, bus_in_q};
    end

    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        addr_d   = addr_q;
        data_d   = data_q;
        bus_in_d = bus_in_q;
        halted_d = chip_out[11];
        if (state_q == S_MEMWAIT) begin
            // An issued read always lands, even if the run request dropped meanwhile.
            bus_in_d = mem_rdata;
            state_d  = (enable && (phase != PH_RW)) ? S_ERR : S_DONE;
        end else if (enable) begin
            if (phase > PH_RW) begin
                state_d = S_ERR;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (phase == PH_OP) begin
                            if ((bus_byte[7:3] == 5'd0) && (bus_byte[2:0] >= OP_MRD) && (bus_byte[2:0] <= OP_COUT)) begin
                                opcode_d = bus_byte[2:0];
                                state_d  = S_GOT_OP;
                            end else begin
                                state_d = S_ERR;
                            end
                        end else if (phase != PH_NONE) begin
                            state_d = S_ERR;
                        end
                    end
                    S_GOT_OP: begin
                        if (phase == PH_HI) begin
                            addr_d[14:8] = bus_byte[6:0];
                            state_d      = S_GOT_HI;
                        end else begin
                            state_d = S_ERR;
                        end
                    end
                    S_GOT_HI: begin
                        if (phase == PH_LO) begin
                            addr_d[7:0] = bus_byte;
                            state_d     = S_GOT_LO;
                        end else begin
                            state_d = S_ERR;
                        end
                    end
                    S_GOT_LO: begin
                        if (phase == PH_RW) begin
                            data_d  = bus_byte;
                            state_d = S_SERVE;
                        end else begin
                            state_d = S_ERR;
                        end
                    end
                    S_SERVE: begin
                        if (phase != PH_RW) begin
                            state_d = S_ERR;
                        end else begin
                            case (opcode_q)
                                OP_MRD: state_d = S_MEMWAIT;
                                OP_MWR: state_d = S_DONE;
                                OP_CIN: begin
                                    if (in_valid) begin
                                        bus_in_d = in_data;
                                        state_d  = S_DONE;
                                    end
                                end
                                OP_COUT: begin
                                    if (out_ready) state_d = S_DONE;
                                end
                                default: state_d = S_ERR;
                            endcase
                        end
                    end
                    S_DONE:  state_d = S_IDLE;
                    default: state_d = state_q;
                endcase
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            opcode_q <= 3'd0;
            addr_q   <= 15'd0;
            data_q   <= 8'd0;
            bus_in_q <= 8'd0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            bus_in_q <= bus_in_d;
            halted_q <= halted_d;
        end
    end

endmodule
